datamem_responder: RTL

- Data-memory responder on the CPU's load/store port: the target end of the datapath's memory access interface.
- Accepts one read or write request at a time over a valid/ready handshake and performs little-endian byte-addressed transfers of 1, 2, 4 or 8 bytes.
- Returns a response after a fixed, parameterised latency, so the CPU can run against slow memory.
- Flags malformed requests instead of corrupting storage.

---
 rtl/datamem_responder_if.sv | 32 +++
 rtl/datamem_responder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/datamem_responder_if.sv
// -----------------------------------------------------------------------------
// datamem_responder_if
//   Load/store port between the CPU datapath (master) and the data-memory
//   responder (slave). Carries a valid/ready request channel and a
//   valid/ready response channel.
//
//   Request  : req_valid, req_ready, req_write, req_addr[63:0],
//              req_wdata[63:0], req_size[3:0] (bytes: 1, 2, 4 or 8)
//   Response : resp_valid, resp_ready, resp_rdata[63:0], resp_err
// -----------------------------------------------------------------------------
interface datamem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [3:0]  req_size;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_size, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_size, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/datamem_responder.sv
// -----------------------------------------------------------------------------
// datamem_responder
//   Byte-addressed little-endian data memory serving one load or store at a
//   time. A response is returned LATENCY cycles after the request is accepted
//   and held until the CPU takes it. Malformed requests (bad size, misaligned,
//   out of range) return resp_err=1 without touching storage.
//
//   Ports:
//     clk    : system clock, all logic on posedge
//     reset  : synchronous active-low reset
//     bus    : datamem_responder_if.slave (request and response channels)
//
//   Parameters:
//     DEPTH_BYTES : storage size in bytes (multiple of 8)
//     LATENCY     : cycles from request acceptance to response (>= 1)
// -----------------------------------------------------------------------------
module datamem_responder #(
   parameter int unsigned DEPTH_BYTES = 1024,
   parameter int unsigned LATENCY     = 2
) (
   input  logic               clk,
   input  logic               reset,
   datamem_responder_if.slave bus
);

   localparam int unsigned   AW        = $clog2(DEPTH_BYTES);
   localparam int unsigned   CW        = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CW-1:0] CNT_LOAD  = CW'(LATENCY - 1);
   localparam logic [64:0]   DEPTH_EXT = 65'(DEPTH_BYTES);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

   state_e        state_q, state_d;
   logic          req_ready;
   logic          accept;
   logic          access;
   logic          mem_we;

   logic          lat_write_q, lat_write_d;
   logic [63:0]   lat_addr_q,  lat_addr_d;
   logic [63:0]   lat_wdata_q, lat_wdata_d;
   logic [3:0]    lat_size_q,  lat_size_d;
   logic [CW-1:0] cnt_q,       cnt_d;
   logic          resp_valid_q, resp_valid_d;
   logic          resp_err_q,   resp_err_d;
   logic [63:0]   resp_rdata_q, resp_rdata_d;

   logic [7:0]    mem [DEPTH_BYTES];
   logic [AW-1:0] byte_idx [8];
   logic [63:0]   rd_data;
   logic          size_ok, align_ok, range_ok, req_err;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // ---------------- FSM: next-state logic ----------------
   // NOTE: combinational blocks use blocking '=' and give every output a
   // default first, so no latch can be inferred; clocked blocks use '<='.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)                state_d = WAIT;
         WAIT:    if (access)                state_d = RESP;
         RESP:    if (bus.resp_ready)        state_d = IDLE;
         default:                            state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      req_ready = (state_q == IDLE) && reset;
      accept    = req_ready && bus.req_valid;
      access    = (state_q == WAIT) && (cnt_q == '0);
      // Gating with reset drops a store whose write edge coincides with reset.
      mem_we    = access && lat_write_q && !req_err && reset;
   end

   // ---------------- request legality (on latched request) ----------------
   always_comb begin
      size_ok  = 1'b0;
      align_ok = 1'b0;
      case (lat_size_q)
         4'd1: begin size_ok = 1'b1; align_ok = 1'b1;                       end
         4'd2: begin size_ok = 1'b1; align_ok = (lat_addr_q[0]   == 1'b0);  end
         4'd4: begin size_ok = 1'b1; align_ok = (lat_addr_q[1:0] == 2'b00); end
         4'd8: begin size_ok = 1'b1; align_ok = (lat_addr_q[2:0] == 3'b000);end
         default: ;
      endcase
      // 65-bit sum so an address near 2^64 cannot wrap into range.
      range_ok = ({1'b0, lat_addr_q} + {61'd0, lat_size_q}) <= DEPTH_EXT;
      req_err  = !(size_ok && align_ok && range_ok);
   end

   // ---------------- byte lanes: lane k maps to address addr+k ----------------
   always_comb begin
      rd_data = '0;
      for (int k = 0; k < 8; k++) begin
         byte_idx[k] = lat_addr_q[AW-1:0] + AW'(k);
         if (4'(k) < lat_size_q) rd_data[8*k +: 8] = mem[byte_idx[k]];
      end
   end

   // NOTE: the storage array is deliberately not reset; reset only clears
   // control and response state, leaving memory contents intact.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int k = 0; k < 8; k++) begin
            if (4'(k) < lat_size_q) mem[byte_idx[k]] <= lat_wdata_q[8*k +: 8];
         end
      end
   end

   // ---------------- datapath next state ----------------
   always_comb begin
      lat_write_d  = lat_write_q;
      lat_addr_d   = lat_addr_q;
      lat_wdata_d  = lat_wdata_q;
      lat_size_d   = lat_size_q;
      cnt_d        = cnt_q;
      resp_valid_d = resp_valid_q;
      resp_err_d   = resp_err_q;
      resp_rdata_d = resp_rdata_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               lat_write_d = bus.req_write;
               lat_addr_d  = bus.req_addr;
               lat_wdata_d = bus.req_wdata;
               lat_size_d  = bus.req_size;
               cnt_d       = CNT_LOAD;
            end
         end
         WAIT: begin
            if (access) begin
               resp_valid_d = 1'b1;
               resp_err_d   = req_err;
               resp_rdata_d = (req_err || lat_write_q) ? 64'd0 : rd_data;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         RESP: begin
            if (bus.resp_ready) begin
               resp_valid_d = 1'b0;
               resp_err_d   = 1'b0;
               resp_rdata_d = 64'd0;
            end
         end
         default: ;
      endcase
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         lat_write_q  <= 1'b0;
         lat_addr_q   <= 64'd0;
         lat_wdata_q  <= 64'd0;
         lat_size_q   <= 4'd0;
         cnt_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 64'd0;
      end else begin
         lat_write_q  <= lat_write_d;
         lat_addr_q   <= lat_addr_d;
         lat_wdata_q  <= lat_wdata_d;
         lat_size_q   <= lat_size_d;
         cnt_q        <= cnt_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   assign bus.req_ready  = req_ready;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.resp_rdata = resp_rdata_q;

endmodule
